aes_ark_stream: RTL and testbench
=================================

Name: aes_ark_stream

Overview:
Streaming, parametrised AddRoundKey stage for the AES core.
- Holds a local round-key table of KEY_SLOTS entries.
- Each accepted beat carries LANES 128-bit state blocks plus a round index.
- Every lane is XORed with the selected round key, and the result is presented through a one-stage registered valid/ready pipeline.
- Sits between SubBytes/ShiftRows/MixColumns stages and the round controller, replacing the single-block enable/done AddRoundKey.

Parameters:
LANES, 1, number of 128-bit blocks processed per beat (same key applied to all lanes)
KEY_SLOTS, 15, round-key table depth (15 covers AES-256, rounds 0..14)
IDX_W, $clog2(KEY_SLOTS), width of round/key index fields
CNT_W, 32, width of processed-beat counter

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous active-high reset
key_we_i  in  1  round-key table write enable
key_addr_i  in  IDX_W  round-key write slot
key_data_i  in  128  round-key write data
key_clear_i  in  1  zeroise key table (see Optional Feature)
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
in_round_i  in  IDX_W  key slot to apply to this beat
in_state_i  in  128*LANES  input state, lane k = bits [128k+127:128k]
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream accepts when out_valid_o & out_ready_i
out_state_o  out  128*LANES  state XOR round key, per lane
out_err_o  out  1  beat used an out-of-range round index
blk_cnt_o  out  CNT_W  number of beats delivered downstream

Behaviour:
- Reset (rst_i=1, async): out_valid_o=0, out_state_o=0, out_err_o=0, blk_cnt_o=0, every key slot=0. in_ready_o=1 once reset is released. Reset mid-stream drops any held beat with no output.
- Pipeline: single output register.
  - in_ready_o = !out_valid_o | out_ready_i. This is a combinational path from out_ready_i; no other combinational in->out path.
  - On accept: register state^key for all lanes, capture err, and set out_valid_o=1 on the next edge. Latency 1 cycle.
  - Full throughput of 1 beat/cycle while out_ready_i=1.
  - Output clears (out_valid_o=0) when it drains with no new accept in the same cycle.
  - Accept and drain in the same cycle: the new beat replaces the old one, out_valid_o stays 1.
- Stall: while out_valid_o=1 and out_ready_i=0, out_state_o and out_err_o hold stable and in_ready_o=0.
- Key table:
  - On key_we_i, slot key_addr_i is written at the edge.
  - key_addr_i >= KEY_SLOTS: the write is ignored.
  - Same-cycle write and accept to the same slot: the accepted beat uses the NEW key_data_i (write-through bypass).
  - Writes never stall the datapath.
- Out-of-range round (in_round_i >= KEY_SLOTS): the beat is still accepted, key treated as all-zero (state passes unchanged), out_err_o=1 for that beat only.
- Counter: blk_cnt_o increments by 1 on every output handshake (out_valid_o & out_ready_i), including error beats. It wraps from 2^CNT_W-1 to 0.
- No X propagation: out_state_o retains its last value when out_valid_o=0.

Optional Feature:
Macro AES_ARK_KEY_CLEAR_EN.
- Defined: key_clear_i=1 zeroises all KEY_SLOTS entries at the edge.
  - Clear has priority over key_we_i in the same cycle.
  - A beat accepted in the same cycle uses a zero key.
  - A beat already in the output register is unaffected.
- Not defined: key_clear_i is ignored (port kept for interface stability); the key table is only cleared by rst_i.

Test Plan:
1. Reset, then load slot 0 = 000102030405060708090a0b0c0d0e0f. Send LANES=1 state 00112233445566778899aabbccddeeff, round 0 with out_ready_i=1 -> one cycle later out_valid_o=1, out_state_o=00102030405060708090a0b0c0d0e0f0, out_err_o=0, blk_cnt_o=1 after the handshake.
2. LANES=4, slots 1..4 loaded with distinct keys, 8 back-to-back beats cycling rounds 1..4 -> one output per cycle, each lane equals its state^key[round], in_ready_o stays 1, blk_cnt_o=8.
3. Backpressure: out_ready_i=0 for 5 cycles with a beat held and in_valid_i=1 -> in_ready_o=0, out_state_o stable. Release -> the held beat drains, then the next beat follows with no loss or duplication.
4. Same-cycle key write to slot 3 (new value K') and accept with in_round_i=3 -> output = state^K'. Write to key_addr_i=15 with KEY_SLOTS=15 -> no slot changes.
5. in_round_i=15 with KEY_SLOTS=15 -> out_state_o = input unchanged, out_err_o=1. The next valid beat has out_err_o=0.
6. With AES_ARK_KEY_CLEAR_EN: pulse key_clear_i together with key_we_i slot 0 -> slot 0 reads 0 afterwards. Without the macro -> keys retained. Assert rst_i with a beat held -> out_valid_o=0 immediately, blk_cnt_o=0.

Source files
------------

// File: rtl/aes_ark_stream_if.sv
// Handshake and key-load bundle for aes_ark_stream.
// The master drives beats and key writes; the slave is the AddRoundKey stage.
interface aes_ark_stream_if #(
  parameter int LANES = 1,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
);
  logic                   key_we_i;
  logic [IDX_W-1:0]       key_addr_i;
  logic [127:0]           key_data_i;
  logic                   key_clear_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [IDX_W-1:0]       in_round_i;
  logic [128*LANES-1:0]   in_state_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [128*LANES-1:0]   out_state_o;
  logic                   out_err_o;
  logic [CNT_W-1:0]       blk_cnt_o;

  modport master (
    output key_we_i, key_addr_i, key_data_i, key_clear_i,
    output in_valid_i, in_round_i, in_state_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_state_o, out_err_o, blk_cnt_o
  );

  modport slave (
    input  key_we_i, key_addr_i, key_data_i, key_clear_i,
    input  in_valid_i, in_round_i, in_state_i, out_ready_i,
    output in_ready_o, out_valid_o, out_state_o, out_err_o, blk_cnt_o
  );
endinterface

// File: rtl/aes_ark_stream.sv
// Streaming AddRoundKey: local round-key table, LANES blocks per beat, one output register.
// Optional key-table zeroise is enabled by defining AES_ARK_KEY_CLEAR_EN.
module aes_ark_stream #(
  parameter int LANES     = 1,
  parameter int KEY_SLOTS = 15,
  parameter int IDX_W     = $clog2(KEY_SLOTS),
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  aes_ark_stream_if.slave  bus
);
  localparam int W = 128 * LANES;

  logic [127:0]     key_q [KEY_SLOTS];
  logic [127:0]     sel_key;
  logic             rnd_err;
  logic             accept;
  logic             drain;
  logic             key_clr;
  logic [W-1:0]     state_d, state_q;
  logic             err_d, err_q;
  logic             vld_d, vld_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

`ifdef AES_ARK_KEY_CLEAR_EN
  assign key_clr = bus.key_clear_i;
`else
  logic unused_key_clear;
  assign unused_key_clear = bus.key_clear_i;
  assign key_clr = 1'b0;
`endif

  assign bus.in_ready_o = !vld_q || bus.out_ready_i;
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign drain          = vld_q && bus.out_ready_i;

  // Key table: clear wins over write; writes to non-existent slots match no entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < KEY_SLOTS; s++) key_q[s] <= '0;
    end else begin
      for (int s = 0; s < KEY_SLOTS; s++) begin
        if (key_clr)
          key_q[s] <= '0;
        else if (bus.key_we_i && bus.key_addr_i == IDX_W'(s))
          key_q[s] <= bus.key_data_i;
      end
    end
  end

  // Round-key select with write-through bypass; out-of-range rounds use a zero key.
  always_comb begin
    sel_key = '0;
    rnd_err = 1'b1;
    for (int s = 0; s < KEY_SLOTS; s++) begin
      if (bus.in_round_i == IDX_W'(s)) begin
        sel_key = key_q[s];
        rnd_err = 1'b0;
      end
    end
    if (bus.key_we_i && !rnd_err && bus.key_addr_i == bus.in_round_i)
      sel_key = bus.key_data_i;
    if (key_clr)
      sel_key = '0;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = bus.in_state_i ^ {LANES{sel_key}};
      err_d   = rnd_err;
      vld_d   = 1'b1;
    end else if (drain) begin
      vld_d   = 1'b0;
    end
    if (drain)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid_o = vld_q;
  assign bus.out_state_o = state_q;
  assign bus.out_err_o   = err_q;
  assign bus.blk_cnt_o   = cnt_q;
endmodule

// File: tb/tb_aes_ark_stream.sv
// Scoreboard bench for aes_ark_stream with LANES=4, KEY_SLOTS=15.
// Directed beats push expectations; a negedge monitor pops them on each output handshake.
module tb_aes_ark_stream;
  localparam int LANES = 4;
  localparam int KEY_SLOTS = 15;
  localparam int IDX_W = 4;
  localparam int CNT_W = 32;
  localparam int W = 128 * LANES;

  typedef struct packed {
    logic [W-1:0] st;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   expect_ready = 1'b0;
  exp_t sb[$];
  logic [127:0] bkey [KEY_SLOTS];
  logic [CNT_W-1:0] cnt_base;

  aes_ark_stream_if #(.LANES(LANES), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  aes_ark_stream #(.LANES(LANES), .KEY_SLOTS(KEY_SLOTS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [127:0] k);
    return {LANES{k}};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %h expected no beat", bus.out_state_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_state", bus.out_state_o, e.st);
        chk("sb_err", W'(bus.out_err_o), W'(e.err));
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic send(input logic [IDX_W-1:0] r, input logic [W-1:0] st,
                      input logic [W-1:0] exp, input bit err);
    exp_t e;
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.in_round_i = r;
    bus.in_state_i = st;
    @(negedge clk);
    if (expect_ready) chk("in_ready_steady", W'(bus.in_ready_o), W'(1));
    while (!bus.in_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    e.st = exp;
    e.err = err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wr_key(input logic [IDX_W-1:0] a, input logic [127:0] d);
    bus.key_we_i = 1'b1;
    bus.key_addr_i = a;
    bus.key_data_i = d;
    @(posedge clk);
    #1;
    bus.key_we_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] st, held;
    logic [127:0] kp;
    for (int s = 0; s < KEY_SLOTS; s++) bkey[s] = '0;
    bus.key_we_i = 1'b0;
    bus.key_addr_i = '0;
    bus.key_data_i = '0;
    bus.key_clear_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_round_i = '0;
    bus.in_state_i = '0;
    bus.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", W'(bus.out_valid_o), '0);
    chk("rst_out_state", bus.out_state_o, '0);
    chk("rst_out_err", W'(bus.out_err_o), '0);
    chk("rst_blk_cnt", W'(bus.blk_cnt_o), '0);
    chk("rst_in_ready", W'(bus.in_ready_o), W'(1));
    tick();

    // 1: single known-answer beat, all lanes identical
    wr_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    bkey[0] = 128'h000102030405060708090a0b0c0d0e0f;
    send(4'd0, rep(128'h00112233445566778899aabbccddeeff),
         rep(128'h00102030405060708090a0b0c0d0e0f0), 1'b0);
    chk("t1_valid_latency", W'(bus.out_valid_o), W'(1));
    chk("t1_state_direct", bus.out_state_o, rep(128'h00102030405060708090a0b0c0d0e0f0));
    tick();
    chk("t1_blk_cnt", W'(bus.blk_cnt_o), W'(1));
    chk("t1_drained", W'(bus.out_valid_o), '0);

    // 2: back-to-back beats cycling rounds 1..4, distinct per-lane state
    for (int r = 1; r <= 4; r++) begin
      bkey[r] = {4{32'hA5C3_0000 + 32'(r * 32'h0101)}} ^ {32'(r), 96'h0};
      wr_key(IDX_W'(r), bkey[r]);
    end
    cnt_base = bus.blk_cnt_o;
    expect_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < LANES; k++)
        st[128*k +: 128] = {4{32'h1000_0000 * k + 32'(b * 7 + 3)}};
      send(IDX_W'(b % 4 + 1), st, st ^ rep(bkey[b % 4 + 1]), 1'b0);
    end
    expect_ready = 1'b0;
    tick();
    chk("t2_blk_cnt", W'(bus.blk_cnt_o - cnt_base), W'(8));

    // 3: backpressure with a held beat and a waiting beat
    bus.out_ready_i = 1'b0;
    st = rep(128'hdeadbeef_01234567_89abcdef_cafef00d);
    held = st ^ rep(bkey[2]);
    send(4'd2, st, held, 1'b0);
    bus.in_valid_i = 1'b1;
    bus.in_round_i = 4'd3;
    bus.in_state_i = rep(128'h5555);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_stall_ready", W'(bus.in_ready_o), '0);
      chk("t3_stall_valid", W'(bus.out_valid_o), W'(1));
      chk("t3_stall_state", bus.out_state_o, held);
    end
    tick();
    cnt_base = bus.blk_cnt_o;
    bus.out_ready_i = 1'b1;
    send(4'd3, rep(128'h5555), rep(128'h5555) ^ rep(bkey[3]), 1'b0);
    tick();
    chk("t3_blk_cnt", W'(bus.blk_cnt_o - cnt_base), W'(2));
    chk("t3_no_dup", W'(bus.out_valid_o), '0);

    // 4: same-cycle write/accept bypass, then ignored out-of-range write
    kp = 128'hfedcba98_76543210_0f0f0f0f_a5a5a5a5;
    bus.key_we_i = 1'b1;
    bus.key_addr_i = 4'd3;
    bus.key_data_i = kp;
    send(4'd3, rep(128'h1111_2222), rep(128'h1111_2222) ^ rep(kp), 1'b0);
    bus.key_we_i = 1'b0;
    bkey[3] = kp;
    wr_key(4'd15, {4{32'hffff_ffff}});
    for (int r = 0; r < 5; r++)
      send(IDX_W'(r), rep(128'h0), rep(bkey[r]), 1'b0);

    // 5: out-of-range round passes state, flags only that beat
    st = rep(128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
    send(4'd15, st, st, 1'b1);
    send(4'd1, st, st ^ rep(bkey[1]), 1'b0);
    tick();

    // 6: clear together with a slot-0 write and a round-1 accept
    bus.key_clear_i = 1'b1;
    bus.key_we_i = 1'b1;
    bus.key_addr_i = 4'd0;
    bus.key_data_i = 128'h9999;
`ifdef AES_ARK_KEY_CLEAR_EN
    send(4'd1, st, st, 1'b0);
    for (int s = 0; s < KEY_SLOTS; s++) bkey[s] = '0;
`else
    send(4'd1, st, st ^ rep(bkey[1]), 1'b0);
    bkey[0] = 128'h9999;
`endif
    bus.key_clear_i = 1'b0;
    bus.key_we_i = 1'b0;
    send(4'd0, st, st ^ rep(bkey[0]), 1'b0);
    send(4'd1, st, st ^ rep(bkey[1]), 1'b0);
    tick();

    // Reset with a beat held in the output register
    bus.out_ready_i = 1'b0;
    send(4'd2, st, st ^ rep(bkey[2]), 1'b0);
    void'(sb.pop_back());
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", W'(bus.out_valid_o), '0);
    chk("rst_mid_cnt", W'(bus.blk_cnt_o), '0);
    chk("rst_mid_state", bus.out_state_o, '0);
    bus.out_ready_i = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", W'(bus.in_ready_o), W'(1));
    for (int s = 0; s < KEY_SLOTS; s++) bkey[s] = '0;
    send(4'd3, st, st, 1'b0);
    repeat (3) tick();
    chk("sb_drained", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
